alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Sequences operations through the gate-level 4-bit ALU, which is instantiated externally and driven via its 12-bit switch-format bus.
- Buffers incoming commands {op, a, b, chain} in a small FIFO and issues them to the ALU one at a time.
- Waits a fixed settle time, then captures the 8-bit result into a registered output with a valid/ready handshake.
- Supports chaining: the previous result's low nibble can replace operand A.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, >=2).
- SETTLE, 2, clock edges between driving alu_sw and capturing alu_led (>=1).

Ports:
- clk  in  1  system clock (single clock domain).
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept (count < DEPTH).
- cmd_op  in  4  ALU opcode (0 add … 15 increment; 3 = divide).
- cmd_a  in  4  operand A.
- cmd_b  in  4  operand B.
- cmd_chain  in  1  use last_result[3:0] as A at issue time.
- alu_sw  out  12  ALU drive bus: {op, b, a}.
- alu_led  in  8  ALU combinational result.
- res_valid  out  1  result held.
- res_ready  in  1  consumer accepts result.
- res_data  out  8  captured result.
- res_op  out  4  opcode of the captured result.
- res_err  out  1  divide-by-zero flag for the current result.
- busy  out  1  state != IDLE or FIFO non-empty.
- fifo_count  out  $clog2(DEPTH)+1  entries buffered.

Behaviour:
- Clock/reset: one clock clk; reset rst_n is asynchronous, active-low. Async assert, synchronous release on clk.
- Reset values: all outputs 0 except cmd_ready=1. alu_sw=0, res_data=0, res_op=0, res_err=0, res_valid=0, fifo_count=0. Internal last_result=0, state=IDLE.
- FIFO:
  - Push on cmd_valid & cmd_ready. Pop only by the FSM.
  - cmd_ready depends only on registered count; a pop in the same cycle does not raise it.
  - Simultaneous push and pop leaves count unchanged.
  - No bypass: a command pushed into an empty FIFO is poppable on the next edge at the earliest.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE: if FIFO non-empty, at the edge: pop head, alu_sw <= {op, b, chain ? last_result[3:0] : a}, latch op/b, cnt <= SETTLE-1, go WAIT.
  - WAIT: if cnt != 0, decrement. If cnt == 0, at the edge:
    - res_data <= alu_led, last_result <= alu_led, res_op <= latched op, res_err <= 0, res_valid <= 1, go HOLD.
    - Exception: if op == 3 and issued B == 0, res_data <= 8'h00, res_err <= 1, and last_result <= 8'h00.
  - HOLD: res_valid, res_data, res_op and res_err are stable until res_ready.
    - On res_valid & res_ready: res_valid <= 0.
    - In the same edge, if FIFO non-empty, pop and issue exactly as in IDLE and go WAIT (back-to-back). Otherwise go IDLE.
- Latency: res_valid rises SETTLE edges after the pop edge. Minimum cmd-push to res_valid latency is SETTLE+1 edges.
- Stability: alu_sw holds its last issued value until the next issue; it is not cleared on capture.
- Chain: a chained command uses the last_result value present at its own issue edge, which is always after the prior capture. With no prior result, A = 0.
- Capacity: with res_ready low, DEPTH+1 commands are accepted (DEPTH buffered plus one in HOLD), then cmd_ready = 0.
- Reset mid-operation: FIFO contents and any in-flight result are discarded; no res_valid pulse after reset deassertion.

Test Plan:
- SUB: push op=1, a=5, b=3, res_ready=1 -> alu_sw=12'h135. res_valid rises 2 edges after the pop with res_data=8'h12, res_op=1, res_err=0.
- Chain: push ADD a=3, b=4, then MUL chain=1, b=2 -> first result 8'h07. Second issue drives alu_sw=12'h227 and yields res_data=8'h0E.
- Backpressure/full: res_ready=0, push 6 back-to-back ADDs -> 5 accepted, cmd_ready=0 with fifo_count=4. res_data stays constant for 20 cycles, then drain returns 5 results in order.
- Divide by zero: op=3, a=7, b=0 -> res_data=8'h00, res_err=1. A following chained INC (op=15) yields 8'h01.
- Back-to-back: 3 queued commands with res_ready held 1 -> results spaced SETTLE+1 edges apart and no IDLE cycle between them. With SETTLE=1, spacing is 2 edges.
- Reset in WAIT: assert rst_n=0 one cycle after an issue with 2 entries queued -> all outputs at reset values immediately. After release, no res_valid appears, fifo_count=0, and busy=0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers {op, a, b, chain} commands in a small FIFO and
// issues them one at a time to an external combinational 4-bit ALU over its
// 12-bit switch bus {op, b, a}. After a fixed settle time the 8-bit ALU result
// is captured into a held output with a valid/ready handshake. A chained
// command replaces operand A with the low nibble of the previous result.
module alu_cmd_sequencer #(
   parameter int DEPTH  = 4,   // FIFO entries, power of two, >= 2
   parameter int SETTLE = 2    // edges between driving alu_sw and capturing alu_led, >= 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [3:0]               cmd_op,
   input  logic [3:0]               cmd_a,
   input  logic [3:0]               cmd_b,
   input  logic                     cmd_chain,
   output logic [11:0]              alu_sw,
   input  logic [7:0]               alu_led,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [7:0]               res_data,
   output logic [3:0]               res_op,
   output logic                     res_err,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [3:0] OP_DIV = 4'd3;

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   typedef struct packed {
      logic [3:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic       chain;
   } cmd_t;

   // ---------------------------------------------------------------- FIFO
   cmd_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          push, pop, fifo_empty;
   cmd_t          head;

   // Ready comes only from the registered count, so a same-cycle pop never raises it.
   assign cmd_ready  = (count_q < (AW+1)'(DEPTH));
   assign push       = cmd_valid & cmd_ready;
   assign fifo_empty = (count_q == '0);
   assign head       = mem_q[rd_ptr_q];
   assign fifo_count = count_q;

   // Command storage; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{op: cmd_op, a: cmd_a, b: cmd_b, chain: cmd_chain};
   end

   // Pointers wrap naturally at DEPTH; count tracks push/pop, unchanged when both occur.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // ---------------------------------------------------------------- FSM
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [11:0]   alu_sw_q, alu_sw_d;
   logic [3:0]    op_q, op_d, b_q, b_d;
   logic [3:0]    last_q, last_d;       // only the low nibble of the last result is ever reused
   logic          res_valid_q, res_valid_d;
   logic [7:0]    res_data_q, res_data_d;
   logic [3:0]    res_op_q, res_op_d;
   logic          res_err_q, res_err_d;
   logic          issue;

   // Next-state logic: issue from IDLE or straight out of HOLD, count down the settle time, capture.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_sw_d    = alu_sw_q;
      op_d        = op_q;
      b_d         = b_q;
      last_d      = last_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_op_d    = res_op_q;
      res_err_d   = res_err_q;
      issue       = 1'b0;
      pop         = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) issue = 1'b1;
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               res_valid_d = 1'b1;
               res_op_d    = op_q;
               state_d     = HOLD;
               // A divide by zero yields a defined zero result rather than whatever the ALU shows.
               if (op_q == OP_DIV && b_q == 4'd0) begin
                  res_data_d = 8'h00;
                  res_err_d  = 1'b1;
                  last_d     = 4'h0;
               end else begin
                  res_data_d = alu_led;
                  res_err_d  = 1'b0;
                  last_d     = alu_led[3:0];
               end
            end
         end
         HOLD: begin
            if (res_valid_q && res_ready) begin
               res_valid_d = 1'b0;
               if (!fifo_empty) issue = 1'b1;
               else             state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (issue) begin
         pop      = 1'b1;
         alu_sw_d = {head.op, head.b, head.chain ? last_q : head.a};
         op_d     = head.op;
         b_d      = head.b;
         cnt_d    = CW'(SETTLE - 1);
         state_d  = WAIT;
      end
   end

   // State and output registers; reset discards any in-flight result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         alu_sw_q    <= '0;
         op_q        <= '0;
         b_q         <= '0;
         last_q      <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_op_q    <= '0;
         res_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alu_sw_q    <= alu_sw_d;
         op_q        <= op_d;
         b_q         <= b_d;
         last_q      <= last_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_op_q    <= res_op_d;
         res_err_q   <= res_err_d;
      end
   end

   assign alu_sw    = alu_sw_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_op    = res_op_q;
   assign res_err   = res_err_q;
   assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small behavioural ALU stub.
module tb_alu_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready;
   logic [3:0]  cmd_op = '0, cmd_a = '0, cmd_b = '0;
   logic        cmd_chain = 1'b0;
   logic [11:0] alu_sw;
   logic [7:0]  alu_led;
   logic        res_valid, res_ready = 1'b0;
   logic [7:0]  res_data;
   logic [3:0]  res_op;
   logic        res_err, busy;
   logic [2:0]  fifo_count;

   int errors = 0;
   int checks = 0;

   alu_cmd_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
      .alu_sw(alu_sw), .alu_led(alu_led),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_op(res_op), .res_err(res_err),
      .busy(busy), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   // ALU stub: sub shows a no-borrow flag in bit 4, divide by zero shows garbage.
   logic [3:0] s_op, s_a, s_b;
   assign {s_op, s_b, s_a} = alu_sw;
   always_comb begin
      alu_led = {s_op, s_a};
      case (s_op)
         4'd0:  alu_led = {4'h0, s_a} + {4'h0, s_b};
         4'd1:  alu_led = {3'b000, (s_a >= s_b), s_a - s_b};
         4'd2:  alu_led = {4'h0, s_a} * {4'h0, s_b};
         4'd3:  alu_led = (s_b == 4'd0) ? 8'hFF : {s_a % s_b, s_a / s_b};
         4'd15: alu_led = {4'h0, s_a} + 8'd1;
         default: alu_led = {s_op, s_a};
      endcase
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic ch);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = ch;
      tick;
      cmd_valid = 1'b0;
      $display("push op=%0d a=%0h b=%0h chain=%0b", op, a, b, ch);
   endtask

   // Bounded wait for res_valid; returns the number of edges waited.
   task automatic wait_res(output int n);
      n = 0;
      while (res_valid !== 1'b1 && n < 50) begin
         tick;
         n++;
      end
      $display("result data=%0h op=%0d err=%0b after %0d edges", res_data, res_op, res_err, n);
   endtask

   initial begin
      int n, acc, nres, bad;
      int t_res[3];
      logic [7:0] got[$];

      // Reset
      #2 rst_n = 1'b0;
      #1;
      chk("rst_cmd_ready", 16'(cmd_ready), 16'd1);
      chk("rst_alu_sw", 16'(alu_sw), 16'h000);
      chk("rst_res", {res_valid, res_err, res_op, res_data}, 16'h0000);
      chk("rst_count_busy", {12'd0, busy, fifo_count}, 16'h0000);
      tick; tick;
      rst_n = 1'b1;
      res_ready = 1'b1;
      tick;

      // SUB with exact latency
      push(4'd1, 4'd5, 4'd3, 1'b0);
      chk("sub_count_after_push", 16'(fifo_count), 16'd1);
      chk("sub_busy", 16'(busy), 16'd1);
      tick;
      chk("sub_alu_sw", 16'(alu_sw), 16'h135);
      chk("sub_count_after_pop", 16'(fifo_count), 16'd0);
      tick;
      chk("sub_not_yet_valid", 16'(res_valid), 16'd0);
      tick;
      chk("sub_valid", 16'(res_valid), 16'd1);
      chk("sub_data", 16'(res_data), 16'h12);
      chk("sub_op_err", {res_op, 3'b0, res_err}, {4'd1, 4'd0});
      tick;
      chk("sub_consumed", {res_valid, busy}, 16'd0);
      chk("sub_alu_sw_held", 16'(alu_sw), 16'h135);

      // Chain: ADD 3+4, then MUL chained with b=2
      push(4'd0, 4'd3, 4'd4, 1'b0);
      push(4'd2, 4'd9, 4'd2, 1'b1);
      chk("chain_alu_sw1", 16'(alu_sw), 16'h043);
      wait_res(n);
      chk("chain_lat1", 16'(n), 16'd2);
      chk("chain_data1", 16'(res_data), 16'h07);
      tick;
      chk("chain_alu_sw2", 16'(alu_sw), 16'h227);
      chk("chain_valid_drop", 16'(res_valid), 16'd0);
      wait_res(n);
      chk("chain_lat2", 16'(n), 16'd2);
      chk("chain_data2", 16'(res_data), 16'h0E);
      chk("chain_op2", 16'(res_op), 16'd2);
      tick;

      // Divide by zero, then chained INC
      push(4'd3, 4'd7, 4'd0, 1'b0);
      wait_res(n);
      chk("div0_latency", 16'(n), 16'd3);
      chk("div0_data", 16'(res_data), 16'h00);
      chk("div0_err_op", {res_op, 3'b0, res_err}, {4'd3, 4'd1});
      push(4'd15, 4'd5, 4'd0, 1'b1);
      tick;
      chk("inc_alu_sw", 16'(alu_sw), 16'hF00);
      wait_res(n);
      chk("inc_data", 16'(res_data), 16'h01);
      chk("inc_err_clear", 16'(res_err), 16'd0);
      tick;

      // Backpressure and capacity
      res_ready = 1'b0;
      acc = 0;
      for (int i = 1; i <= 6; i++) begin
         cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = i[3:0]; cmd_b = 4'd1; cmd_chain = 1'b0;
         if (cmd_ready) acc++;
         tick;
         $display("offer a=%0d ready_seen_total=%0d count=%0d", i, acc, fifo_count);
      end
      cmd_valid = 1'b0;
      chk("full_accepted", 16'(acc), 16'd5);
      chk("full_ready_count", {cmd_ready, fifo_count}, {1'b0, 3'd4});
      chk("full_first_result", {res_valid, res_data}, {1'b1, 8'h02});
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (res_valid !== 1'b1 || res_data !== 8'h02) bad++;
      end
      chk("hold_stable", 16'(bad), 16'd0);
      res_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (res_valid === 1'b1) begin
            got.push_back(res_data);
            $display("drain result %0d data=%0h", got.size(), res_data);
         end
         tick;
      end
      chk("drain_count", 16'(got.size()), 16'd5);
      for (int k = 0; k < got.size() && k < 5; k++)
         chk($sformatf("drain_data%0d", k), 16'(got[k]), 16'(k + 2));

      // Back-to-back issue
      nres = 0; bad = 0;
      for (int c = 0; c < 20; c++) begin
         if (c < 3) begin
            cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 4'(c + 1); cmd_b = 4'(c + 1); cmd_chain = 1'b0;
         end else begin
            cmd_valid = 1'b0;
         end
         tick;
         if (res_valid === 1'b1 && nres < 3) begin
            t_res[nres] = c;
            $display("b2b result %0d data=%0h at step %0d", nres, res_data, c);
            chk($sformatf("b2b_data%0d", nres), 16'(res_data), 16'(2 * (nres + 1)));
            nres++;
         end
         if (nres < 3 && busy !== 1'b1) bad++;
      end
      chk("b2b_nres", 16'(nres), 16'd3);
      if (nres == 3) begin
         chk("b2b_space1", 16'(t_res[1] - t_res[0]), 16'd3);
         chk("b2b_space2", 16'(t_res[2] - t_res[1]), 16'd3);
      end
      chk("b2b_busy", 16'(bad), 16'd0);

      // Reset in WAIT with two queued
      for (int c = 0; c < 3; c++) begin
         cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 4'd7; cmd_b = 4'(c); cmd_chain = 1'b0;
         tick;
      end
      cmd_valid = 1'b0;
      chk("pre_rst_count", 16'(fifo_count), 16'd2);
      chk("pre_rst_alu_sw", 16'(alu_sw), 16'h007);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_count_busy", {12'd0, busy, fifo_count}, 16'h0000);
      chk("mid_rst_res", {res_valid, res_err, res_op, res_data}, 16'h0000);
      chk("mid_rst_sw_ready", {cmd_ready, alu_sw}, {1'b1, 12'h000});
      tick; tick;
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick;
         if (res_valid !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0) bad++;
      end
      chk("post_rst_quiet", 16'(bad), 16'd0);
      push(4'd0, 4'd9, 4'd5, 1'b1);
      tick;
      chk("post_rst_chain_sw", 16'(alu_sw), 16'h050);
      wait_res(n);
      chk("post_rst_chain_data", 16'(res_data), 16'h05);
      tick;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
